// File: rtl/refill_arbiter_pkg.sv
// Shared types and constants for the cache refill arbiter and related arbiters.
package refill_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    // Bit of the AXI beat tag that marks the final beat of a transaction.
    localparam int RLAST_LAST_BIT = 0;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/refill_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N. Shared by the refill and writeback arbiters.
module rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    int best;
    int off;

    // NOTE: every output and temporary gets a default before any conditional
    // assignment, so no path through the block leaves a value held (no latch).
    always_comb begin
        best  = N;
        off   = 0;
        idx   = '0;
        grant = '0;
        // Distance from ptr decides priority; the smallest distance wins.
        for (int j = 0; j < N; j++) begin
            off = (j >= int'(ptr)) ? j - int'(ptr) : j - int'(ptr) + N;
            if (req[j] && off < best) begin
                best = off;
                idx  = IDX_W'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            grant[j] = (best < N) && (idx == IDX_W'(j));
        end
    end

endmodule

// File: rtl/refill_arbiter.sv
// Shares one AXI read-controller port among NREQ cache refill requesters.
// Define REFILL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module refill_arbiter
    import refill_arbiter_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_rreq_i,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr_i,
    output logic [NREQ-1:0]            req_rdy_o,
    output logic [NREQ-1:0]            req_rvalid_o,
    output logic [NREQ*2-1:0]          req_rlast_o,
    output logic [DATA_WIDTH-1:0]      req_data_o,
    output logic                       axi_rreq_o,
    output logic [ADDR_WIDTH-1:0]      axi_addr_o,
    input  logic                       axi_rdy_i,
    input  logic                       axi_rvalid_i,
    input  logic [1:0]                 axi_rlast_i,
    input  logic [DATA_WIDTH-1:0]      axi_data_i
);

    localparam int PTR_W = $clog2(NREQ);

    arb_state_e       state_r, state_nxt;
    logic [NREQ-1:0]  grant_r, grant_nxt;
    logic [PTR_W-1:0] grant_idx_r, grant_idx_nxt;
    logic [PTR_W-1:0] rr_ptr;
    logic [NREQ-1:0]  pick_grant;
    logic [PTR_W-1:0] pick_idx;
    logic             gnt_rreq;
    logic             last_beat;

    rr_picker #(
        .N     (NREQ),
        .IDX_W (PTR_W)
    ) u_picker (
        .req   (req_rreq_i),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    assign gnt_rreq  = |(req_rreq_i & grant_r);
    assign last_beat = axi_rvalid_i && axi_rlast_i[RLAST_LAST_BIT];

    always_comb begin
        state_nxt     = state_r;
        grant_nxt     = grant_r;
        grant_idx_nxt = grant_idx_r;
        case (state_r)
            IDLE: begin
                if (|req_rreq_i) begin
                    state_nxt     = REQ;
                    grant_nxt     = pick_grant;
                    grant_idx_nxt = pick_idx;
                end
            end
            REQ: begin
                // A requester withdrawing before acceptance aborts without
                // consuming its round-robin turn.
                if (!gnt_rreq) begin
                    state_nxt = IDLE;
                end else if (axi_rdy_i) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (last_beat) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the clock edge, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            grant_r     <= '0;
            grant_idx_r <= '0;
        end else begin
            state_r     <= state_nxt;
            grant_r     <= grant_nxt;
            grant_idx_r <= grant_idx_nxt;
        end
    end

`ifdef REFILL_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (state_r == WAIT && last_beat) begin
            rr_ptr <= PTR_W'(wrap_inc(int'(grant_idx_r), NREQ));
        end
    end
`endif

    always_comb begin
        axi_rreq_o   = 1'b0;
        axi_addr_o   = '0;
        req_rdy_o    = '0;
        req_rvalid_o = '0;
        req_rlast_o  = '0;
        req_data_o   = '0;
        case (state_r)
            REQ: begin
                axi_rreq_o = gnt_rreq;
                for (int i = 0; i < NREQ; i++) begin
                    if (grant_idx_r == PTR_W'(i)) begin
                        axi_addr_o = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                    end
                    req_rdy_o[i] = grant_r[i] & axi_rdy_i;
                end
            end
            WAIT: begin
                req_data_o = axi_data_i;
                // Beats keep draining after a requester drops rreq; only the
                // valid strobe is hidden from it.
                for (int i = 0; i < NREQ; i++) begin
                    req_rvalid_o[i] = grant_r[i] & axi_rvalid_i & req_rreq_i[i];
                    if (grant_r[i]) begin
                        req_rlast_o[i*2 +: 2] = axi_rlast_i;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_refill_arbiter.sv
// Scoreboard bench for refill_arbiter: directed stimulus pushes expected
// events; a negedge monitor pops and compares whenever the DUT presents one.
module tb_refill_arbiter;

    typedef enum int {EV_REQ, EV_RDY, EV_BEAT} ev_e;

    typedef struct {
        ev_e          kind;
        logic [31:0]  addr;
        logic [1:0]   vec;
        logic [127:0] data;
        logic [3:0]   rlast;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req_rreq = '0;
    logic [31:0]  addr0 = '0;
    logic [31:0]  addr1 = '0;
    logic [1:0]   req_rdy;
    logic [1:0]   req_rvalid;
    logic [3:0]   req_rlast;
    logic [127:0] req_data;
    logic         axi_rreq;
    logic [31:0]  axi_addr;
    logic         axi_rdy = 1'b0;
    logic         axi_rvalid = 1'b0;
    logic [1:0]   axi_rlast = '0;
    logic [127:0] axi_data = '0;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_rreq = 1'b0;

    localparam logic [31:0] A0 = 32'h1000_0040;
    localparam logic [31:0] A1 = 32'h2000_0080;

    always #5 clk = ~clk;

    refill_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_rreq_i   (req_rreq),
        .req_addr_i   ({addr1, addr0}),
        .req_rdy_o    (req_rdy),
        .req_rvalid_o (req_rvalid),
        .req_rlast_o  (req_rlast),
        .req_data_o   (req_data),
        .axi_rreq_o   (axi_rreq),
        .axi_addr_o   (axi_addr),
        .axi_rdy_i    (axi_rdy),
        .axi_rvalid_i (axi_rvalid),
        .axi_rlast_i  (axi_rlast),
        .axi_data_i   (axi_data)
    );

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input ev_e k, input logic [31:0] a, input logic [1:0] v,
                        input logic [127:0] d, input logic [3:0] rl);
        exp_t e;
        e.kind  = k;
        e.addr  = a;
        e.vec   = v;
        e.data  = d;
        e.rlast = rl;
        sb.push_back(e);
    endtask

    task automatic exp_txn(input int port, input logic [31:0] a, input int nbeats, input logic [127:0] base);
        logic [1:0] v;
        logic [3:0] rv;
        v       = '0;
        v[port] = 1'b1;
        push(EV_REQ, a, '0, '0, '0);
        push(EV_RDY, '0, v, '0, '0);
        for (int b = 0; b < nbeats; b++) begin
            rv = '0;
            rv[port*2 +: 2] = (b == nbeats - 1) ? 2'b01 : 2'b00;
            push(EV_BEAT, '0, v, base + 128'(b), rv);
        end
    endtask

    task automatic pop_cmp(input ev_e kind);
        exp_t e;
        check("sb_has_entry", sb.size() != 0, 1'b1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("ev_kind", e.kind, kind);
        case (kind)
            EV_REQ:  check("axi_addr", axi_addr, e.addr);
            EV_RDY:  check("req_rdy", req_rdy, e.vec);
            default: begin
                check("req_rvalid", req_rvalid, e.vec);
                check("req_data", req_data, e.data);
                check("req_rlast", req_rlast, e.rlast);
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (axi_rreq && !prev_rreq) pop_cmp(EV_REQ);
        prev_rreq = axi_rreq;
        if (|req_rdy) pop_cmp(EV_RDY);
        if (|req_rvalid) pop_cmp(EV_BEAT);
    end

    task automatic do_reset();
        rst        = 1'b1;
        req_rreq   = '0;
        axi_rdy    = 1'b0;
        axi_rvalid = 1'b0;
        axi_rlast  = '0;
        axi_data   = '0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!axi_rreq && n < 50) begin
            tick();
            n++;
        end
        check(name, axi_rreq, 1'b1);
    endtask

    // Entered in the first REQ cycle; returns in the IDLE cycle after the last beat.
    task automatic axi_txn(input int rdy_delay, input int nbeats, input logic [127:0] base, input int gap);
        repeat (rdy_delay) tick();
        axi_rdy = 1'b1;
        tick();
        axi_rdy = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            repeat (gap) tick();
            axi_rvalid = 1'b1;
            axi_rlast  = (b == nbeats - 1) ? 2'b01 : 2'b00;
            axi_data   = base + 128'(b);
            tick();
            axi_rvalid = 1'b0;
            axi_rlast  = '0;
            axi_data   = '0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq2[3];
        int seq4;
        int seq6[11];
        int p0cnt;
        int p;
`ifdef REFILL_ARB_FIXED_PRIO_EN
        seq2 = '{0, 0, 0};
        seq4 = 0;
        seq6 = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
`else
        seq2 = '{0, 1, 0};
        seq4 = 1;
        seq6 = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
`endif
        // Reset state
        do_reset();
        check("rst_axi_rreq", axi_rreq, 1'b0);
        check("rst_axi_addr", axi_addr, '0);
        check("rst_req_rdy", req_rdy, '0);
        check("rst_req_rvalid", req_rvalid, '0);
        check("rst_req_rlast", req_rlast, '0);
        check("rst_req_data", req_data, '0);

        // 1: single request with exact cycle latencies
        addr0 = 32'h1C00_0100;
        exp_txn(0, addr0, 1, {16{8'hA5}});
        req_rreq = 2'b01;
        #1 check("t1_c0_no_rreq", axi_rreq, 1'b0);
        tick();
        check("t1_c1_rreq", axi_rreq, 1'b1);
        check("t1_c1_addr", axi_addr, 32'h1C00_0100);
        check("t1_c1_no_rdy", req_rdy, 2'b00);
        tick();
        tick();
        axi_rdy = 1'b1;
        #1 check("t1_c3_rdy", req_rdy, 2'b01);
        tick();
        axi_rdy = 1'b0;
        #1 check("t1_c4_rreq_low", axi_rreq, 1'b0);
        tick();
        tick();
        axi_rvalid = 1'b1;
        axi_rlast  = 2'b01;
        axi_data   = {16{8'hA5}};
        #1 check("t1_c6_rvalid", req_rvalid, 2'b01);
        check("t1_c6_data", req_data, {16{8'hA5}});
        tick();
        req_rreq = 2'b00;
        #1 check("t1_c7_idle_ignores_beat", req_rvalid, 2'b00);
        check("t1_c7_idle_data", req_data, '0);
        tick();
        axi_rvalid = 1'b0;
        axi_rlast  = '0;
        axi_data   = '0;

        // 2: simultaneous requests held high, back-to-back grants
        do_reset();
        addr0 = A0;
        addr1 = A1;
        for (int k = 0; k < 3; k++) begin
            exp_txn(seq2[k], (seq2[k] == 1) ? A1 : A0, 1, 128'h2000 + 128'(k * 16));
            if (k == 0) begin
                req_rreq = 2'b11;
                wait_req("t2_wait_req");
            end else begin
                #1 check("t2_gap_idle", axi_rreq, 1'b0);
                tick();
                check("t2_b2b_grant", axi_rreq, 1'b1);
            end
            axi_txn(1, 1, 128'h2000 + 128'(k * 16), 0);
        end
        req_rreq = 2'b00;

        // 3: multi-beat on port 1
        exp_txn(1, A1, 3, 128'h3000);
        req_rreq = 2'b10;
        wait_req("t3_wait_req");
        axi_txn(2, 3, 128'h3000, 1);
        req_rreq = 2'b00;

        // 4: abort in REQ keeps rr_ptr; stray beat in IDLE is ignored
        do_reset();
        exp_txn(0, A0, 1, 128'h4000);
        req_rreq = 2'b01;
        wait_req("t4_wait_p0");
        axi_txn(0, 1, 128'h4000, 0);
        req_rreq = 2'b00;
        push(EV_REQ, A1, '0, '0, '0);
        req_rreq = 2'b10;
        wait_req("t4_wait_p1");
        tick();
        req_rreq = 2'b00;
        #1 check("t4_abort_same_cycle", axi_rreq, 1'b0);
        tick();
        axi_rvalid = 1'b1;
        axi_rlast  = 2'b01;
        axi_data   = {4{32'hFFFF_FFFF}};
        #1 check("t4_stray_rvalid", req_rvalid, 2'b00);
        check("t4_stray_rlast", req_rlast, 4'b0000);
        check("t4_stray_data", req_data, '0);
        check("t4_idle_no_rreq", axi_rreq, 1'b0);
        tick();
        axi_rvalid = 1'b0;
        axi_rlast  = '0;
        axi_data   = '0;
        exp_txn(seq4, (seq4 == 1) ? A1 : A0, 1, 128'h4100);
        req_rreq = 2'b11;
        wait_req("t4_wait_pair");
        axi_txn(0, 1, 128'h4100, 0);
        req_rreq = 2'b00;

        // 5: reset while in WAIT drops the rest of the transaction
        do_reset();
        push(EV_REQ, A0, '0, '0, '0);
        push(EV_RDY, '0, 2'b01, '0, '0);
        push(EV_BEAT, '0, 2'b01, 128'h5000, 4'b0000);
        req_rreq = 2'b01;
        wait_req("t5_wait_req");
        axi_rdy = 1'b1;
        tick();
        axi_rdy    = 1'b0;
        axi_rvalid = 1'b1;
        axi_rlast  = 2'b00;
        axi_data   = 128'h5000;
        tick();
        axi_rvalid = 1'b0;
        axi_data   = '0;
        rst        = 1'b1;
        req_rreq   = 2'b00;
        tick();
        rst        = 1'b0;
        axi_rvalid = 1'b1;
        axi_rlast  = 2'b01;
        axi_data   = 128'h5001;
        #1 check("t5_axi_rreq", axi_rreq, 1'b0);
        check("t5_axi_addr", axi_addr, '0);
        check("t5_req_rdy", req_rdy, '0);
        check("t5_req_rvalid", req_rvalid, '0);
        check("t5_req_rlast", req_rlast, '0);
        check("t5_req_data", req_data, '0);
        tick();
        axi_rvalid = 1'b0;
        axi_rlast  = '0;
        axi_data   = '0;
        exp_txn(0, A0, 1, 128'h5100);
        req_rreq = 2'b01;
        wait_req("t5_wait_after_rst");
        axi_txn(0, 1, 128'h5100, 0);
        req_rreq = 2'b00;

        // 6: port 0 streams ten transactions; port 1 asserts once
        do_reset();
        p0cnt    = 0;
        req_rreq = 2'b01;
        for (int k = 0; k < 11; k++) begin
            p = seq6[k];
            exp_txn(p, (p == 1) ? A1 : A0, 1, 128'h6000 + 128'(k));
            wait_req("t6_wait_req");
            if (k == 2) req_rreq[1] = 1'b1;
            axi_txn(0, 1, 128'h6000 + 128'(k), 0);
            if (p == 1) begin
                req_rreq[1] = 1'b0;
            end else begin
                p0cnt++;
                if (p0cnt == 10) req_rreq[0] = 1'b0;
            end
        end
        req_rreq = 2'b00;
        repeat (3) tick();

        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
